// File: rtl/char_ram_write_arbiter.sv
// Round-robin arbiter for the single character-RAM write port.
// Also contains a sequencer that fills the whole RAM with CLEAR_CHAR.
module char_ram_write_arbiter #(
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 60,
   parameter logic [6:0]  CLEAR_CHAR = 7'd32
) (
   input  logic        clock50MHz,
   input  logic        resetn,
   input  logic [2:0]  reqValid,
   input  logic [38:0] reqAddr,
   input  logic [20:0] reqData,
   output logic [2:0]  reqReady,
   input  logic        clearStart,
   output logic        clearBusy,
   output logic        charRamWrEn,
   output logic [12:0] charRamAddr,
   output logic [6:0]  charRamData
);

   localparam int unsigned NP    = 3;
   localparam int unsigned AW    = 13;
   localparam int unsigned DW    = 7;
   localparam int unsigned DEPTH = COLS * ROWS;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {ARB, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [1:0]      last_q, last_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;

   logic [1:0]      cand_c;
   logic [1:0]      sel_c;
   logic            found_c;
   logic [AW-1:0]   sel_addr_c;
   logic [DW-1:0]   sel_data_c;
   logic [NP-1:0]   ready_c;

   // First valid port after the last grant, wrapping modulo NP
   always_comb begin
      cand_c  = 2'd0;
      sel_c   = 2'd0;
      found_c = 1'b0;
      for (int unsigned i = 1; i <= NP; i++) begin
         cand_c = 2'((32'(last_q) + i) % NP);
         if (!found_c && reqValid[cand_c]) begin
            found_c = 1'b1;
            sel_c   = cand_c;
         end
      end
      sel_addr_c = reqAddr[32'(sel_c) * AW +: AW];
      sel_data_c = reqData[32'(sel_c) * DW +: DW];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      ready_c = '0;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ARB: begin
            if (clearStart) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (found_c) begin
               ready_c[sel_c] = 1'b1;
               last_d         = sel_c;
               // Out-of-range addresses are consumed but never written
               if (32'(sel_addr_c) < DEPTH) begin
                  wr_en_d = 1'b1;
                  addr_d  = sel_addr_c;
                  data_d  = sel_data_c;
               end
            end
         end
         CLEAR: begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = CLEAR_CHAR;
            if (cnt_q == LAST_ADDR) begin
               state_d = ARB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clock50MHz) begin
      if (!resetn) begin
         state_q <= ARB;
         cnt_q   <= '0;
         last_q  <= 2'd2;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // No grant may be seen while reset is held
   assign reqReady    = ready_c & {NP{resetn}};
   assign clearBusy   = (state_q == CLEAR);
   assign charRamWrEn = wr_en_q;
   assign charRamAddr = addr_q;
   assign charRamData = data_q;

endmodule

// File: tb/tb_char_ram_write_arbiter.sv
// Random and directed stimulus for char_ram_write_arbiter, checked against
// a countdown/round-robin reference model.
module tb_char_ram_write_arbiter;

   localparam int unsigned COLS = 80;
   localparam int unsigned ROWS = 60;
   localparam int unsigned N    = COLS * ROWS;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  reqValid;
   logic [38:0] reqAddr;
   logic [20:0] reqData;
   logic [2:0]  reqReady;
   logic        clearStart;
   logic        clearBusy;
   logic        wr;
   logic [12:0] addr;
   logic [6:0]  data;

   int errors = 0;
   int checks = 0;

   int unsigned p_addr [3];
   int unsigned p_data [3];

   // Reference model state
   int          m_clear_left = 0;
   int          m_last       = 2;
   int          m_gp         = -1;
   logic        m_wr         = 1'b0;
   logic [12:0] m_addr       = '0;
   logic [6:0]  m_data       = '0;
   logic [2:0]  m_ready      = '0;

   always #10 clk = ~clk;

   char_ram_write_arbiter #(.COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(7'd32)) dut (
      .clock50MHz  (clk),
      .resetn      (resetn),
      .reqValid    (reqValid),
      .reqAddr     (reqAddr),
      .reqData     (reqData),
      .reqReady    (reqReady),
      .clearStart  (clearStart),
      .clearBusy   (clearBusy),
      .charRamWrEn (wr),
      .charRamAddr (addr),
      .charRamData (data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check the combinational grant, advance the model, check outputs
   task automatic step();
      int p;
      for (int i = 0; i < 3; i++) begin
         reqAddr[13*i +: 13] = 13'(p_addr[i]);
         reqData[7*i +: 7]   = 7'(p_data[i]);
      end
      m_gp    = -1;
      m_ready = '0;
      if (resetn && m_clear_left == 0 && !clearStart) begin
         for (int i = 1; i <= 3; i++) begin
            p = (m_last + i) % 3;
            if (m_gp < 0 && reqValid[p]) m_gp = p;
         end
      end
      if (m_gp >= 0) m_ready[m_gp] = 1'b1;
      #5;
      chk("reqReady", 32'(reqReady), 32'(m_ready));

      if (!resetn) begin
         m_wr = 1'b0; m_addr = '0; m_data = '0; m_clear_left = 0; m_last = 2;
      end else if (m_clear_left > 0) begin
         m_wr   = 1'b1;
         m_addr = 13'(N - 32'(m_clear_left));
         m_data = 7'd32;
         m_clear_left--;
      end else if (clearStart) begin
         m_wr         = 1'b0;
         m_clear_left = N;
      end else if (m_gp >= 0) begin
         m_last = m_gp;
         if (p_addr[m_gp] < N) begin
            m_wr   = 1'b1;
            m_addr = 13'(p_addr[m_gp]);
            m_data = 7'(p_data[m_gp]);
         end else begin
            m_wr = 1'b0;
         end
      end else begin
         m_wr = 1'b0;
      end

      @(posedge clk);
      #1;
      chk("charRamWrEn", 32'(wr), 32'(m_wr));
      chk("charRamAddr", 32'(addr), 32'(m_addr));
      chk("charRamData", 32'(data), 32'(m_data));
      chk("clearBusy", 32'(clearBusy), 32'(m_clear_left > 0));
   endtask

   task automatic new_req(input int i);
      reqValid[i] = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) p_addr[i] = N + $urandom_range(8191 - N);
      else                        p_addr[i] = $urandom_range(N - 1);
      p_data[i] = $urandom_range(127);
   endtask

   task automatic set_port(input int i, input logic v, input int unsigned a, input int unsigned d);
      reqValid[i] = v;
      p_addr[i]   = a;
      p_data[i]   = d;
   endtask

   initial begin
      int guard;
      resetn = 1'b0; clearStart = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0;
      for (int i = 0; i < 3; i++) begin p_addr[i] = 0; p_data[i] = 0; end

      // Reset with random inputs
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 3; i++) new_req(i);
         clearStart = 1'($urandom_range(1));
         step();
      end
      chk("reset_wr", 32'(wr), 32'd0);
      chk("reset_addr", 32'(addr), 32'd0);
      chk("reset_busy", 32'(clearBusy), 32'd0);

      resetn = 1'b1; clearStart = 1'b0; reqValid = '0;
      step();

      // Single write on port 1
      set_port(1, 1'b1, 66, 48);
      step();
      reqValid = '0;
      chk("single_wr", 32'(wr), 32'd1);
      chk("single_addr", 32'(addr), 32'd66);
      chk("single_data", 32'(data), 32'd48);
      step();
      chk("single_once", 32'(wr), 32'd0);

      // Round-robin with all ports, then with port 1 dropped
      set_port(0, 1'b1, 10, 1); set_port(1, 1'b1, 20, 2); set_port(2, 1'b1, 30, 3);
      repeat (9) step();
      reqValid[1] = 1'b0;
      repeat (6) step();
      reqValid = '0;
      step();

      // Clear wins over a simultaneous request, which is served afterwards
      set_port(0, 1'b1, 5, 65);
      clearStart = 1'b1;
      step();
      clearStart = 1'b0;
      repeat (N) step();
      chk("clear_last_addr", 32'(addr), 32'(N - 1));
      step();
      reqValid = '0;
      chk("after_clear_wr", 32'(wr), 32'd1);
      chk("after_clear_addr", 32'(addr), 32'd5);
      chk("after_clear_data", 32'(data), 32'd65);

      // Out-of-range address is consumed without a write
      set_port(2, 1'b1, 4800, 70);
      step();
      reqValid = '0;
      chk("oor_wr", 32'(wr), 32'd0);
      step();

      // Random traffic honouring the hold-until-ready rule
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++)
            if (!(reqValid[i] && !m_ready[i] && $urandom_range(9) != 0)) new_req(i);
         clearStart = ($urandom_range(1499) == 0);
         step();
      end
      clearStart = 1'b0;
      reqValid = '0;
      guard = 0;
      while (m_clear_left > 0 && guard < 6000) begin step(); guard++; end
      chk("drain_clear", 32'(m_clear_left), 32'd0);

      // Reset in the middle of a clear abandons it
      clearStart = 1'b1;
      step();
      clearStart = 1'b0;
      guard = 0;
      while (!(m_wr && m_addr == 13'd1000) && guard < 6000) begin step(); guard++; end
      chk("midclear_addr", 32'(addr), 32'd1000);
      resetn = 1'b0;
      step();
      chk("midclear_wr", 32'(wr), 32'd0);
      chk("midclear_busy", 32'(clearBusy), 32'd0);
      resetn = 1'b1;
      repeat (20) step();
      chk("no_resume", 32'(wr), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
